// File: rtl/pwm_seq_ctrl_if.sv
// PWM channel link: sequencer drives channel config,
// channel returns its single-cycle overflow pulse.
interface pwm_seq_ctrl_if;
   logic        pwm_enb;
   logic        pwm_run;
   logic [15:0] pwm_comp0;
   logic        pwm_ovflow_pe;

   modport master (
      output pwm_enb,
      output pwm_run,
      output pwm_comp0,
      input  pwm_ovflow_pe
   );

   modport slave (
      input  pwm_enb,
      input  pwm_run,
      input  pwm_comp0,
      output pwm_ovflow_pe
   );
endinterface

// File: rtl/pwm_seq_ctrl.sv
// Steps one PWM channel through a table of compare-0 values,
// holding each entry for rpt+1 overflow periods.
module pwm_seq_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          mclk,
   input  logic          h_reset,
   input  logic          seq_start,
   input  logic          seq_stop,
   input  logic [AW:0]   cfg_seq_len,
   input  logic [7:0]    cfg_seq_rpt,
   input  logic          cfg_seq_loop,
   input  logic          tbl_wr_en,
   input  logic [AW-1:0] tbl_wr_addr,
   input  logic [15:0]   tbl_wr_data,
   pwm_seq_ctrl_if.master pwm,
   output logic          seq_busy,
   output logic [AW-1:0] seq_idx,
   output logic          seq_done,
   output logic          seq_err
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   state_t        state_q;
   state_t        state_d;
   logic [15:0]   tbl [DEPTH];
   logic [AW:0]   len_l;
   logic [7:0]    rpt_l;
   logic          loop_l;
   logic [7:0]    rpt_q;
   logic [7:0]    rpt_d;
   logic [AW-1:0] idx_q;
   logic [AW-1:0] idx_d;
   logic [AW-1:0] nxt_idx;
   logic [AW:0]   last_idx;
   logic [15:0]   comp_q;
   logic [15:0]   comp_d;
   logic          wr_ok;
   logic          len_ok;
   logic          latch;
   logic          err_d;
   logic          enb_q;
   logic          run_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;

   assign wr_ok    = tbl_wr_en && (state_q == IDLE);
   assign len_ok   = (cfg_seq_len != '0) &&
                     (cfg_seq_len <= LEN_MAX);
   assign nxt_idx  = idx_q + AW'(1);
   assign last_idx = len_l - (AW+1)'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rpt_d   = rpt_q;
      comp_d  = comp_q;
      latch   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (seq_start) begin
               if (len_ok) begin
                  state_d = LOAD;
                  idx_d   = '0;
                  rpt_d   = '0;
                  latch   = 1'b1;
                  // a same-cycle write to entry 0 must be seen
                  if (wr_ok && tbl_wr_addr == '0)
                     comp_d = tbl_wr_data;
                  else
                     comp_d = tbl[0];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if (pwm.pwm_ovflow_pe) begin
               if (rpt_q != rpt_l) begin
                  rpt_d = rpt_q + 8'd1;
               end else begin
                  rpt_d = '0;
                  if ({1'b0, idx_q} != last_idx) begin
                     idx_d  = nxt_idx;
                     comp_d = tbl[nxt_idx];
                  end else if (loop_l) begin
                     idx_d  = '0;
                     comp_d = tbl[0];
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE: state_d = IDLE;
      endcase
      if (tbl_wr_en && state_q != IDLE)
         err_d = 1'b1;
      if (seq_stop && state_q != IDLE) begin
         state_d = IDLE;
         idx_d   = idx_q;
         rpt_d   = rpt_q;
         comp_d  = comp_q;
      end
   end

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rpt_q   <= '0;
         comp_q  <= '0;
         len_l   <= '0;
         rpt_l   <= '0;
         loop_l  <= 1'b0;
         enb_q   <= 1'b0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rpt_q   <= rpt_d;
         comp_q  <= comp_d;
         if (latch) begin
            len_l  <= cfg_seq_len;
            rpt_l  <= cfg_seq_rpt;
            loop_l <= cfg_seq_loop;
         end
         // outputs follow the next state so they are registered
         enb_q  <= (state_d == LOAD) || (state_d == RUN);
         run_q  <= (state_d == RUN);
         busy_q <= (state_d != IDLE);
         done_q <= (state_d == DONE);
         err_q  <= err_d;
      end
   end

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         for (int i = 0; i < DEPTH; i++)
            tbl[i] <= '0;
      end else if (wr_ok) begin
         tbl[tbl_wr_addr] <= tbl_wr_data;
      end
   end

   assign pwm.pwm_enb   = enb_q;
   assign pwm.pwm_run   = run_q;
   assign pwm.pwm_comp0 = comp_q;
   assign seq_busy      = busy_q;
   assign seq_idx       = idx_q;
   assign seq_done      = done_q;
   assign seq_err       = err_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: overflow-count model plus
// directed vectors with literal expectations.
module tb_pwm_seq_ctrl;

   logic        mclk = 1'b0;
   logic        h_reset = 1'b1;
   logic        seq_start = 1'b0;
   logic        seq_stop = 1'b0;
   logic [3:0]  cfg_seq_len = '0;
   logic [7:0]  cfg_seq_rpt = '0;
   logic        cfg_seq_loop = 1'b0;
   logic        tbl_wr_en = 1'b0;
   logic [2:0]  tbl_wr_addr = '0;
   logic [15:0] tbl_wr_data = '0;
   logic        seq_busy;
   logic [2:0]  seq_idx;
   logic        seq_done;
   logic        seq_err;

   pwm_seq_ctrl_if pwm_if ();

   pwm_seq_ctrl #(.DEPTH(8), .AW(3)) dut (
      .mclk         (mclk),
      .h_reset      (h_reset),
      .seq_start    (seq_start),
      .seq_stop     (seq_stop),
      .cfg_seq_len  (cfg_seq_len),
      .cfg_seq_rpt  (cfg_seq_rpt),
      .cfg_seq_loop (cfg_seq_loop),
      .tbl_wr_en    (tbl_wr_en),
      .tbl_wr_addr  (tbl_wr_addr),
      .tbl_wr_data  (tbl_wr_data),
      .pwm          (pwm_if),
      .seq_busy     (seq_busy),
      .seq_idx      (seq_idx),
      .seq_done     (seq_done),
      .seq_err      (seq_err)
   );

   always #5 mclk = ~mclk;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // model: phase 0 idle, 1 first cycle, 2 counting, 3 finishing;
   // the active entry is derived from the overflow count k
   int          m_phase = 0;
   int          m_k = 0;
   int          m_len = 0;
   int          m_rpt = 0;
   bit          m_loop = 1'b0;
   logic [15:0] m_tbl [8];
   logic [15:0] e_comp = '0;
   logic [2:0]  e_idx = '0;
   logic        e_err = 1'b0;
   logic        e_done = 1'b0;

   always @(posedge mclk) begin
      int e;
      e_err  = 1'b0;
      e_done = 1'b0;
      if (h_reset) begin
         m_phase = 0;
         m_k     = 0;
         e_comp  = '0;
         e_idx   = '0;
         for (int i = 0; i < 8; i++) m_tbl[i] = '0;
      end else begin
         if (tbl_wr_en && m_phase != 0) e_err = 1'b1;
         if (tbl_wr_en && m_phase == 0)
            m_tbl[tbl_wr_addr] = tbl_wr_data;
         if (seq_stop && m_phase != 0) begin
            m_phase = 0;
         end else begin
            case (m_phase)
               0: if (seq_start) begin
                  if (cfg_seq_len >= 1 && cfg_seq_len <= 8) begin
                     m_len   = int'(cfg_seq_len);
                     m_rpt   = int'(cfg_seq_rpt);
                     m_loop  = cfg_seq_loop;
                     m_k     = 0;
                     m_phase = 1;
                     e_idx   = '0;
                     e_comp  = m_tbl[0];
                  end else begin
                     e_err = 1'b1;
                  end
               end
               1: m_phase = 2;
               2: if (pwm_if.pwm_ovflow_pe) begin
                  m_k++;
                  if (m_loop) m_k = m_k % (m_len * (m_rpt + 1));
                  e = m_k / (m_rpt + 1);
                  if (e < m_len) begin
                     e_idx  = 3'(e);
                     e_comp = m_tbl[e];
                  end else begin
                     m_phase = 3;
                     e_done  = 1'b1;
                  end
               end
               default: m_phase = 0;
            endcase
         end
      end
   end

   always @(negedge mclk) begin
      if (chk_en) begin
         check("m_enb", pwm_if.pwm_enb,
               m_phase == 1 || m_phase == 2);
         check("m_run", pwm_if.pwm_run, m_phase == 2);
         check("m_busy", seq_busy, m_phase != 0);
         check("m_comp", pwm_if.pwm_comp0, e_comp);
         check("m_idx", seq_idx, e_idx);
         check("m_done", seq_done, e_done);
         check("m_err", seq_err, e_err);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge mclk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      tbl_wr_en = 1'b1;
      tbl_wr_addr = a;
      tbl_wr_data = d;
      tick(1);
      tbl_wr_en = 1'b0;
   endtask

   task automatic cfg(input int len, input int rpt, input bit lp);
      cfg_seq_len = 4'(len);
      cfg_seq_rpt = 8'(rpt);
      cfg_seq_loop = lp;
   endtask

   task automatic start();
      seq_start = 1'b1;
      tick(1);
      seq_start = 1'b0;
   endtask

   task automatic ovf();
      pwm_if.pwm_ovflow_pe = 1'b1;
      tick(1);
      pwm_if.pwm_ovflow_pe = 1'b0;
   endtask

   logic [2:0]  idx_seq [9];
   logic [15:0] cmp_seq [9];

   initial begin
      pwm_if.pwm_ovflow_pe = 1'b0;
      idx_seq = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
      cmp_seq = '{10, 10, 20, 20, 20, 10, 10, 10, 20};
      tick(1);
      chk_en = 1'b1;
      tick(1);
      check("rst_enb", pwm_if.pwm_enb, 0);
      check("rst_comp", pwm_if.pwm_comp0, 0);
      check("rst_busy", seq_busy, 0);
      h_reset = 1'b0;

      wr(0, 100);
      wr(1, 200);
      wr(2, 300);
      cfg(3, 0, 0);
      start();
      check("t1_enb", pwm_if.pwm_enb, 1);
      check("t1_run0", pwm_if.pwm_run, 0);
      check("t1_comp0", pwm_if.pwm_comp0, 100);
      tick(1);
      check("t1_run1", pwm_if.pwm_run, 1);
      ovf();
      check("t1_comp1", pwm_if.pwm_comp0, 200);
      tick(2);
      ovf();
      check("t1_comp2", pwm_if.pwm_comp0, 300);
      ovf();
      check("t1_done", seq_done, 1);
      check("t1_enb_off", pwm_if.pwm_enb, 0);
      check("t1_busy_dn", seq_busy, 1);
      tick(1);
      check("t1_done_off", seq_done, 0);
      check("t1_idle", seq_busy, 0);

      wr(0, 10);
      wr(1, 20);
      cfg(2, 2, 1);
      start();
      tick(1);
      for (int i = 0; i < 9; i++) begin
         ovf();
         check("t2_idx", seq_idx, idx_seq[i]);
         check("t2_comp", pwm_if.pwm_comp0, cmp_seq[i]);
         tick(1);
      end

      ovf();
      ovf();
      seq_stop = 1'b1;
      pwm_if.pwm_ovflow_pe = 1'b1;
      tick(1);
      seq_stop = 1'b0;
      pwm_if.pwm_ovflow_pe = 1'b0;
      check("t3_busy", seq_busy, 0);
      check("t3_comp", pwm_if.pwm_comp0, 20);
      check("t3_idx", seq_idx, 1);
      tick(2);

      cfg(0, 0, 0);
      start();
      check("t4_err0", seq_err, 1);
      check("t4_busy0", seq_busy, 0);
      tick(1);
      check("t4_err_off", seq_err, 0);
      cfg(9, 0, 0);
      start();
      check("t4_err9", seq_err, 1);
      check("t4_busy9", seq_busy, 0);
      tick(1);

      cfg(2, 0, 0);
      start();
      tick(1);
      wr(1, 16'hBEEF);
      check("t5_err", seq_err, 1);
      ovf();
      check("t5_comp", pwm_if.pwm_comp0, 20);
      ovf();
      check("t5_done", seq_done, 1);
      tick(2);

      cfg(2, 1, 0);
      start();
      pwm_if.pwm_ovflow_pe = 1'b1;
      tick(1);
      pwm_if.pwm_ovflow_pe = 1'b0;
      check("t6_idx0", seq_idx, 0);
      ovf();
      check("t6_idx1", seq_idx, 0);
      ovf();
      check("t6_idx2", seq_idx, 1);
      h_reset = 1'b1;
      tick(1);
      h_reset = 1'b0;
      check("t6_rst_comp", pwm_if.pwm_comp0, 0);
      check("t6_rst_busy", seq_busy, 0);
      check("t6_rst_idx", seq_idx, 0);
      tick(1);

      cfg(1, 0, 0);
      tbl_wr_en = 1'b1;
      tbl_wr_addr = 3'd0;
      tbl_wr_data = 16'h1234;
      seq_start = 1'b1;
      tick(1);
      tbl_wr_en = 1'b0;
      seq_start = 1'b0;
      check("t7_comp", pwm_if.pwm_comp0, 16'h1234);
      tick(1);
      ovf();
      check("t7_done", seq_done, 1);
      tick(3);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
